// File: rtl/uart_rx_packet_ctrl_pkg.sv
// Shared definitions for the UART receive packet path.
//   - rx_state_e : framing FSM encodings (HUNT=0, LEN=1, PAYLOAD=2, CHECK=3, EMIT=4)
//   - rx_err_e   : err_code values reported on the error pulse
//   - rx_err_t   : one-cycle error event (fire + code) produced by the FSM
//   - SYNC_BYTE_DEFAULT : default packet start marker
//   - baud_div() : 16x oversample divider, truncated, floored at 2
package uart_rx_packet_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_HUNT    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CHECK   = 3'd3,
    ST_EMIT    = 3'd4
  } rx_state_e;

  typedef enum logic [1:0] {
    ERR_BAD_LEN  = 2'd0,
    ERR_CHECKSUM = 2'd1,
    ERR_TIMEOUT  = 2'd2,
    ERR_OVERRUN  = 2'd3
  } rx_err_e;

  typedef struct packed {
    logic    fire;
    rx_err_e code;
  } rx_err_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // Integer-truncated CLK_HZ/(BAUD*16); a divider below 2 cannot produce
  // a one-cycle pulse followed by an idle cycle, so clamp it.
  function automatic int baud_div(input int clk_hz, input int baud);
    int d;
    d = clk_hz / (baud * 16);
    return (d < 2) ? 2 : d;
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Free-running 16x oversample tick generator.
// Ports:
//   clk_50m : system clock
//   rst     : asynchronous active-high reset, restarts the count at 0
//   tick    : high for exactly one cycle every DIV cycles (count == DIV-1)
// Shared with the transmitter, so it carries no receiver-specific logic.
module baud_tick_gen
  import uart_rx_packet_ctrl_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200
) (
  input  logic clk_50m,
  input  logic rst,
  output logic tick
);

  localparam int DIV = baud_div(CLK_HZ, BAUD);
  localparam int CW  = $clog2(DIV);

  logic [CW-1:0] cnt;

  // Decoded straight from the count so the reset value (count 0) gives tick=0.
  assign tick = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst)       cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/uart_rx_packet_ctrl.sv
// Receive-side sequencer between the UART byte engine and the command decoder.
// Drives the receiver's oversample clken, drains bytes over ready/ready_clr,
// frames SYNC, LEN, payload, CHK packets, buffers the payload and releases it
// on a valid/ready stream only once the XOR checksum has verified.
// Ports:
//   clk_50m      : system clock
//   rst          : asynchronous active-high reset (drops any partial packet)
//   rx_clken     : one-cycle oversample tick to the receiver
//   rx_ready     : receiver byte-ready flag
//   rx_data      : receiver byte
//   rx_ready_clr : active-low clear back to the receiver, low one cycle per byte
//   pkt_valid    : payload byte valid
//   pkt_data     : payload byte (0 when not valid)
//   pkt_last     : final payload byte of the packet
//   pkt_ready    : downstream accept
//   err_valid    : one-cycle error pulse
//   err_code     : 0 bad_len, 1 checksum, 2 timeout, 3 overrun (held after pulse)
module uart_rx_packet_ctrl
  import uart_rx_packet_ctrl_pkg::*;
#(
  parameter int         CLK_HZ        = 50000000,
  parameter int         BAUD          = 115200,
  parameter logic [7:0] SYNC_BYTE     = SYNC_BYTE_DEFAULT,
  parameter int         MAX_LEN       = 16,
  parameter int         TIMEOUT_TICKS = 320
) (
  input  logic       clk_50m,
  input  logic       rst,
  output logic       rx_clken,
  input  logic       rx_ready,
  input  logic [7:0] rx_data,
  output logic       rx_ready_clr,
  output logic       pkt_valid,
  output logic [7:0] pkt_data,
  output logic       pkt_last,
  input  logic       pkt_ready,
  output logic       err_valid,
  output logic [1:0] err_code
);

  localparam int         IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int         TW        = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  rx_state_e  state, state_d;
  logic [7:0] len, len_d;
  logic [7:0] idx, idx_d;
  logic [7:0] chk, chk_d;
  logic [TW-1:0] tmo, tmo_d;
  logic       buf_we;
  rx_err_t    err_d;

  logic [7:0] pbuf [MAX_LEN];
  logic [IDX_W-1:0] bidx;

  logic cap, in_frame, expire, last_byte;

  // ---------------------------------------------------------------------------
  // Oversample tick
  // ---------------------------------------------------------------------------
  baud_tick_gen #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) u_tick (
    .clk_50m (clk_50m),
    .rst     (rst),
    .tick    (rx_clken)
  );

  // A byte is taken only while our clear is released; the cycle after a
  // capture holds clear low, so a ready flag still high then is ignored.
  assign cap       = rx_ready && rx_ready_clr;
  assign in_frame  = (state == ST_LEN) || (state == ST_PAYLOAD) || (state == ST_CHECK);
  // Expiry is the tick that would bring the gap counter to TIMEOUT_TICKS.
  assign expire    = rx_clken && (tmo == TW'(TIMEOUT_TICKS - 1));
  assign last_byte = (idx == len - 8'd1);
  assign bidx      = idx[IDX_W-1:0];

  // ---------------------------------------------------------------------------
  // State register and datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      state        <= ST_HUNT;
      len          <= '0;
      idx          <= '0;
      chk          <= '0;
      tmo          <= '0;
      rx_ready_clr <= 1'b1;
      err_valid    <= 1'b0;
      err_code     <= 2'd0;
    end else begin
      state        <= state_d;
      len          <= len_d;
      idx          <= idx_d;
      chk          <= chk_d;
      tmo          <= tmo_d;
      rx_ready_clr <= !cap;
      err_valid    <= err_d.fire;
      if (err_d.fire) err_code <= err_d.code;
    end
  end

  // Payload store; contents are only read in EMIT after being written.
  always_ff @(posedge clk_50m) begin
    if (buf_we) pbuf[bidx] <= rx_data;
  end

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state;
    len_d      = len;
    idx_d      = idx;
    chk_d      = chk;
    tmo_d      = '0;
    buf_we     = 1'b0;
    err_d.fire = 1'b0;
    err_d.code = ERR_BAD_LEN;

    // Inter-byte gap counter runs only while a packet is being assembled.
    if (in_frame) tmo_d = cap ? '0 : (rx_clken ? tmo + 1'b1 : tmo);

    case (state)
      ST_HUNT: begin
        if (cap && rx_data == SYNC_BYTE) state_d = ST_LEN;
      end
      ST_LEN: begin
        if (cap) begin
          if (rx_data == 8'd0 || rx_data > MAX_LEN_B) begin
            err_d.fire = 1'b1;
            err_d.code = ERR_BAD_LEN;
            state_d    = ST_HUNT;
          end else begin
            len_d   = rx_data;
            chk_d   = rx_data;
            idx_d   = '0;
            state_d = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (cap) begin
          buf_we = 1'b1;
          chk_d  = chk ^ rx_data;
          idx_d  = idx + 8'd1;
          if (idx_d == len) state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (cap) begin
          if (rx_data == chk) begin
            idx_d   = '0;
            state_d = ST_EMIT;
          end else begin
            err_d.fire = 1'b1;
            err_d.code = ERR_CHECKSUM;
            state_d    = ST_HUNT;
          end
        end
      end
      ST_EMIT: begin
        // Bytes arriving while the payload drains are acknowledged and lost.
        if (cap) begin
          err_d.fire = 1'b1;
          err_d.code = ERR_OVERRUN;
        end
        if (pkt_valid && pkt_ready) begin
          if (last_byte) begin
            idx_d   = '0;
            state_d = ST_HUNT;
          end else begin
            idx_d = idx + 8'd1;
          end
        end
      end
      default: state_d = ST_HUNT;
    endcase

    // A byte landing on the expiry tick keeps the packet alive.
    if (in_frame && expire && !cap) begin
      err_d.fire = 1'b1;
      err_d.code = ERR_TIMEOUT;
      tmo_d      = '0;
      state_d    = ST_HUNT;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    pkt_valid = 1'b0;
    pkt_data  = '0;
    pkt_last  = 1'b0;
    if (state == ST_EMIT) begin
      pkt_valid = 1'b1;
      pkt_data  = pbuf[bidx];
      pkt_last  = last_byte;
    end
  end

endmodule

// File: tb/tb_uart_rx_packet_ctrl.sv
module tb_uart_rx_packet_ctrl;

  logic       clk_50m = 1'b0;
  logic       rst = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       pkt_ready = 1'b1;
  logic       rx_clken, rx_ready_clr, pkt_valid, pkt_last, err_valid;
  logic [7:0] pkt_data;
  logic [1:0] err_code;

  always #10 clk_50m = ~clk_50m;

  uart_rx_packet_ctrl dut (
    .clk_50m      (clk_50m),
    .rst          (rst),
    .rx_clken     (rx_clken),
    .rx_ready     (rx_ready),
    .rx_data      (rx_data),
    .rx_ready_clr (rx_ready_clr),
    .pkt_valid    (pkt_valid),
    .pkt_data     (pkt_data),
    .pkt_last     (pkt_last),
    .pkt_ready    (pkt_ready),
    .err_valid    (err_valid),
    .err_code     (err_code)
  );

  int n_chk = 0;
  int n_err = 0;
  int pr_mode = 0;  // 0 always ready, 1 pattern 1,0,0, 2 never ready

  // monitor captures
  logic [7:0] got_d[$];
  logic       got_l[$];
  logic [1:0] got_e[$];
  int         clr_lows = 0;
  int         valid_seen = 0;

  // vector table: stimulus bytes and expected payload live in flat pools
  typedef struct {
    int bofs; int nb; int pr; int eofs; int en; int err;
  } vec_t;
  vec_t       vecs[$];
  logic [7:0] pool[$];
  logic [7:0] epool[$];
  logic [7:0] s[$];
  logic [7:0] e[$];
  int         resync_id;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk_50m); #1; end
  endtask

  task automatic clear_mon();
    got_d.delete(); got_l.delete(); got_e.delete();
    clr_lows = 0; valid_seen = 0;
  endtask

  // Receiver model: hold ready until our clear is seen low.
  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    rx_data = b; rx_ready = 1'b1;
    do begin cyc(1); n++; end while (rx_ready_clr && n < 20);
    chk("send_ack", rx_ready_clr, 0);
    rx_ready = 1'b0;
  endtask

  task automatic add(input int pr, input int err);
    vec_t t;
    t.bofs = pool.size(); t.nb = s.size(); t.eofs = epool.size(); t.en = e.size();
    t.pr = pr; t.err = err;
    foreach (s[i]) pool.push_back(s[i]);
    foreach (e[i]) epool.push_back(e[i]);
    vecs.push_back(t);
  endtask

  task automatic apply_vec(input int v);
    vec_t t;
    t = vecs[v];
    pr_mode = t.pr;
    clear_mon();
    for (int k = 0; k < t.nb; k++) send(pool[t.bofs + k]);
    cyc(80);
    chk($sformatf("v%0d_clr_pulses", v), clr_lows, t.nb);
    chk($sformatf("v%0d_xfers", v), got_d.size(), t.en);
    for (int k = 0; k < t.en && k < got_d.size(); k++) begin
      chk($sformatf("v%0d_data%0d", v, k), got_d[k], epool[t.eofs + k]);
      chk($sformatf("v%0d_last%0d", v, k), got_l[k], (k == t.en - 1));
    end
    chk($sformatf("v%0d_any_valid", v), valid_seen != 0, t.en != 0);
    if (t.err < 0) chk($sformatf("v%0d_err_cnt", v), got_e.size(), 0);
    else begin
      chk($sformatf("v%0d_err_cnt", v), got_e.size(), 1);
      if (got_e.size() > 0) chk($sformatf("v%0d_err_code", v), got_e[0], t.err);
    end
    pr_mode = 0;
  endtask

  // downstream ready driver
  initial begin
    int c;
    c = 0;
    forever begin
      cyc(1);
      c++;
      case (pr_mode)
        0:       pkt_ready = 1'b1;
        1:       pkt_ready = (c % 3 == 0);
        default: pkt_ready = 1'b0;
      endcase
    end
  end

  // output monitor, sampled mid-cycle
  initial begin
    logic       stall_q;
    logic [7:0] stall_d;
    logic       stall_l;
    stall_q = 1'b0; stall_d = '0; stall_l = 1'b0;
    forever begin
      @(negedge clk_50m);
      if (rst) stall_q = 1'b0;
      else begin
        if (!rx_ready_clr) clr_lows++;
        if (pkt_valid) valid_seen++;
        if (err_valid) got_e.push_back(err_code);
        if (stall_q) begin
          chk("stall_valid", pkt_valid, 1);
          chk("stall_data", pkt_data, stall_d);
          chk("stall_last", pkt_last, stall_l);
        end
        if (pkt_valid && pkt_ready) begin
          got_d.push_back(pkt_data);
          got_l.push_back(pkt_last);
        end
        stall_q = pkt_valid && !pkt_ready;
        stall_d = pkt_data;
        stall_l = pkt_last;
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_clken"}, rx_clken, 0);
    chk({tag, "_clr"}, rx_ready_clr, 1);
    chk({tag, "_valid"}, pkt_valid, 0);
    chk({tag, "_data"}, pkt_data, 0);
    chk({tag, "_last"}, pkt_last, 0);
    chk({tag, "_err_valid"}, err_valid, 0);
    chk({tag, "_err_code"}, err_code, 0);
  endtask

  initial begin
    int n, ticks;

    // ---- vector table ----
    s = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03}; e = {8'h11, 8'h22, 8'h33}; add(0, -1);
    s = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03}; e = {8'h11, 8'h22, 8'h33}; add(1, -1);
    s = {8'hA5, 8'h00}; e.delete(); add(0, 0);
    resync_id = vecs.size();
    s = {8'h00, 8'hFF, 8'hA5, 8'h01, 8'h7E, 8'h7F}; e = {8'h7E}; add(0, -1);
    s = {8'hA5, 8'h02, 8'hAA, 8'hBB, 8'h00}; e.delete(); add(0, 1);
    s = {8'hA5, 8'h02, 8'h01, 8'h02, 8'h01}; e = {8'h01, 8'h02}; add(0, -1);
    s = {8'hA5, 8'h11}; e.delete(); add(0, 0);
    s = {8'hA5, 8'h10}; e.delete();
    for (int i = 0; i < 16; i++) begin s.push_back(8'(i)); e.push_back(8'(i)); end
    s.push_back(8'h10);
    add(0, -1);

    // ---- reset state ----
    rst = 1'b1;
    cyc(3);
    chk_reset_outputs("rst");
    rst = 1'b0;

    // ---- tick generator ----
    n = 0;
    while (!rx_clken && n < 100) begin cyc(1); n++; end
    chk("tick_first", n, 26);
    cyc(1);
    chk("tick_width", rx_clken, 0);
    n = 1;
    while (!rx_clken && n < 100) begin cyc(1); n++; end
    chk("tick_period1", n, 27);
    cyc(1);
    n = 1;
    while (!rx_clken && n < 100) begin cyc(1); n++; end
    chk("tick_period2", n, 27);
    // reset on the tick cycle itself
    rst = 1'b1;
    #1;
    chk("tick_rst_clken", rx_clken, 0);
    cyc(2);
    rst = 1'b0;
    n = 0;
    while (!rx_clken && n < 100) begin cyc(1); n++; end
    chk("tick_restart", n, 26);

    // ---- table ----
    for (int v = 0; v < vecs.size(); v++) apply_vec(v);

    // ---- timeout after AA ----
    clear_mon();
    send(8'hA5); send(8'h02); send(8'hAA);
    ticks = 0; n = 0;
    while (!err_valid && n < 12000) begin
      if (rx_clken) ticks++;
      cyc(1); n++;
    end
    chk("to_ticks", ticks, 320);
    chk("to_err_valid", err_valid, 1);
    chk("to_code", err_code, 2);
    cyc(1);
    chk("to_pulse_width", err_valid, 0);
    chk("to_code_hold", err_code, 2);
    chk("to_no_pkt", valid_seen, 0);
    apply_vec(resync_id);

    // ---- byte on the expiry tick wins ----
    clear_mon();
    send(8'hA5); send(8'h02); send(8'hAA);
    ticks = 0; n = 0;
    while (n < 12000) begin
      if (rx_clken) ticks++;
      if (ticks == 320) break;
      cyc(1); n++;
    end
    chk("exp_ticks", ticks, 320);
    rx_data = 8'hBB; rx_ready = 1'b1;
    cyc(1);
    chk("exp_captured", rx_ready_clr, 0);
    rx_ready = 1'b0;
    send(8'h13);
    cyc(40);
    chk("exp_err_cnt", got_e.size(), 0);
    chk("exp_xfers", got_d.size(), 2);
    if (got_d.size() == 2) begin
      chk("exp_d0", got_d[0], 8'hAA);
      chk("exp_d1", got_d[1], 8'hBB);
    end

    // ---- overrun during a stalled EMIT ----
    clear_mon();
    pr_mode = 2;
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h03);
    cyc(3);
    chk("ovr_valid", pkt_valid, 1);
    chk("ovr_data_before", pkt_data, 8'h11);
    send(8'h55);
    cyc(2);
    chk("ovr_err_cnt", got_e.size(), 1);
    if (got_e.size() > 0) chk("ovr_code", got_e[0], 3);
    chk("ovr_data_after", pkt_data, 8'h11);
    pr_mode = 0;
    cyc(20);
    chk("ovr_xfers", got_d.size(), 3);
    if (got_d.size() == 3) begin
      chk("ovr_d0", got_d[0], 8'h11);
      chk("ovr_d1", got_d[1], 8'h22);
      chk("ovr_d2", got_d[2], 8'h33);
      chk("ovr_l1", got_l[1], 0);
      chk("ovr_l2", got_l[2], 1);
    end
    chk("ovr_clr_pulses", clr_lows, 7);

    // ---- reset mid-packet discards it ----
    send(8'hA5); send(8'h03); send(8'h11);
    rst = 1'b1;
    cyc(2);
    chk_reset_outputs("midrst");
    rst = 1'b0;
    cyc(2);
    apply_vec(resync_id);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
